// File: rtl/trng_pkg.sv
// trng_pkg: shared debias state type, default sizing and helpers for the TRNG collector
package trng_pkg;
  typedef enum logic {EMPTY, HAVE_FIRST} db_state_e;
  localparam int NUM_RO_DEF = 8;
  localparam int WORD_WIDTH_DEF = 32;
  localparam int SAMPLE_DIV_DEF = 4;
  localparam int RCT_CUTOFF_DEF = 32;
  function automatic int fill_w(input int ww);
    return $clog2(ww + 1);
  endfunction
endpackage

// File: rtl/trng_sync.sv
// trng_sync: 2-flop synchroniser for one asynchronous bit, reset to 0
module trng_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ff_q <= '0;
    else ff_q <= {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/trng_collector.sv
// trng_collector: XOR-combined ring oscillators -> sync, decimate, von Neumann debias, word packing.
// Define TRNG_HEALTH_EN to add a repetition-count health test that blocks word transfers on failure.
import trng_pkg::*;
module trng_collector #(
  parameter int NUM_RO = NUM_RO_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_RO-1:0]     ro_in,
  input  logic                  enable,
  output logic [WORD_WIDTH-1:0] rnd_data,
  output logic                  rnd_valid,
  input  logic                  rnd_ready,
  output logic                  overrun,
  output logic                  health_fail
);
  localparam int CW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam int FW = fill_w(WORD_WIDTH);
  if (NUM_RO < 2 || WORD_WIDTH < 2 || SAMPLE_DIV < 1 || RCT_CUTOFF < 2) begin : g_bad_param
    $error("trng_collector: illegal parameter value");
  end
  logic synced, strobe, cb_v, full, xfer, hf;
  logic [CW-1:0] cnt_q, cnt_d;
  db_state_e state_q, state_d;
  logic b0_q, b0_d, valid_q, valid_d, ovr_q, ovr_d;
  logic [WORD_WIDTH-1:0] sh_q, sh_d, data_q, data_d;
  logic [FW-1:0] fill_q, fill_d;
  trng_sync u_sync (.clk(clk), .rst(rst), .d_i(^ro_in), .q_o(synced));
  always_comb begin
    strobe = enable && cnt_q == CW'(SAMPLE_DIV - 1);
    cnt_d = (!enable || strobe) ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    b0_d = b0_q;
    cb_v = 1'b0;
    if (!enable) state_d = EMPTY;
    else if (strobe) begin
      state_d = state_q == EMPTY ? HAVE_FIRST : EMPTY;
      b0_d = state_q == EMPTY ? synced : b0_q;
      cb_v = state_q == HAVE_FIRST && synced != b0_q;
    end
  end
  // The holding register may reload in the same cycle it is consumed.
  always_comb begin
    full = fill_q == FW'(WORD_WIDTH);
    xfer = full && (!valid_q || rnd_ready) && !hf;
    data_d = xfer ? sh_q : data_q;
    valid_d = xfer || (valid_q && !rnd_ready);
    sh_d = sh_q;
    fill_d = fill_q;
    ovr_d = ovr_q;
    if (!enable) begin
      sh_d = '0;
      fill_d = '0;
    end else if (xfer) begin
      sh_d = WORD_WIDTH'(b0_q & cb_v);
      fill_d = FW'(cb_v);
    end else if (cb_v && full) ovr_d = 1'b1;
    else if (cb_v) begin
      sh_d = {sh_q[WORD_WIDTH-2:0], b0_q};
      fill_d = fill_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      state_q <= EMPTY;
      b0_q <= 1'b0;
      sh_q <= '0;
      fill_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      state_q <= state_d;
      b0_q <= b0_d;
      sh_q <= sh_d;
      fill_q <= fill_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
    end
`ifdef TRNG_HEALTH_EN
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  logic [RW-1:0] run_q, run_d;
  logic last_q, last_d, hf_q, hf_d;
  always_comb begin
    run_d = run_q;
    last_d = last_q;
    hf_d = hf_q;
    if (strobe) begin
      run_d = (run_q == '0 || synced != last_q) ? RW'(1) : run_q == RW'(RCT_CUTOFF) ? run_q : run_q + 1'b1;
      last_d = synced;
      hf_d = hf_q || run_d == RW'(RCT_CUTOFF);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      run_q <= '0;
      last_q <= 1'b0;
      hf_q <= 1'b0;
    end else begin
      run_q <= run_d;
      last_q <= last_d;
      hf_q <= hf_d;
    end
  assign hf = hf_q;
`else
  assign hf = 1'b0;
`endif
  assign rnd_data = data_q;
  assign rnd_valid = valid_q;
  assign overrun = ovr_q;
  assign health_fail = hf;
endmodule

// File: doc/trng_collector.md
Name: trng_collector

Overview:
- Parametrised successor to the ring-oscillator XOR combiner.
- Takes NUM_RO free-running oscillator outputs and XORs them into one raw bit.
- Synchronises and decimates that bit, then removes bias with a von Neumann corrector.
- Packs the corrected bits into WORD_WIDTH-bit words for a valid/ready consumer.
- Sits between the oscillator bank and the TRNG register interface.

Parameters:
- NUM_RO, 8: number of oscillator inputs XOR-combined; must be ≥ 2.
- WORD_WIDTH, 32: output word width in bits; must be ≥ 2.
- SAMPLE_DIV, 4: clocks per sample strobe; must be ≥ 1.
- RCT_CUTOFF, 32: repetition-count limit; used only with TRNG_HEALTH_EN.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: reset, asynchronous, active-high.
- ro_in, input, NUM_RO: asynchronous oscillator outputs.
- enable, input, 1: collection enable.
- rnd_data, output, WORD_WIDTH: random word.
- rnd_valid, output, 1: rnd_data holds an unconsumed word.
- rnd_ready, input, 1: consumer accepts the word.
- overrun, output, 1: sticky flag; a corrected bit was dropped.
- health_fail, output, 1: sticky repetition-count failure.

Behaviour:
- Reset: all outputs and all internal state go to 0, including sample counter, debias state, fill count, shift register and holding register.
- Raw path: raw = XOR of all ro_in bits, formed combinationally, then passed through a 2-flop synchroniser. A change on raw appears on the synced bit 2 clocks later.
- Sample counter:
  - Counts 0 to SAMPLE_DIV-1 and wraps.
  - Strobe fires in the cycle where count == SAMPLE_DIV-1.
  - When enable=0, counter is held at 0.
- Debias FSM, states EMPTY and HAVE_FIRST, advancing on strobes only:
  - EMPTY: latch the synced bit as b0, go to HAVE_FIRST.
  - HAVE_FIRST: on b1, return to EMPTY. If b0≠b1, emit b0 as one corrected bit; if equal, emit nothing.
  - enable=0 forces EMPTY and clears the shift register and fill count.
  - Holding register and rnd_valid are unaffected by enable.
- Packer:
  - Each corrected bit enters at the LSB and the register shifts left, so the first bit ends at the MSB.
  - fill counts 0 to WORD_WIDTH.
  - When fill == WORD_WIDTH and the holding register is free, the word transfers to the holding register and fill returns to 0.
  - The holding register counts as free when rnd_valid=0, or when rnd_valid=1 and rnd_ready=1 in the same cycle.
  - A corrected bit arriving in the transfer cycle goes into the emptied shift register at fill=1 and is not lost.
  - If fill == WORD_WIDTH and the holding register is not free, a new corrected bit is discarded and overrun is set. overrun clears only on reset.
- Output handshake:
  - rnd_valid rises the cycle after transfer.
  - rnd_data is stable while rnd_valid=1 and rnd_ready=0.
  - Transfer happens when rnd_valid and rnd_ready are both 1. rnd_valid falls next cycle unless a full word is transferred in that same cycle, in which case rnd_valid stays 1 with the new data.
  - rnd_ready while rnd_valid=0 has no effect.
- Minimum latency from enable to first rnd_valid: 2·WORD_WIDTH strobes plus 3 clocks.
- Reset mid-word discards all partial state. The asynchronous reset assert drops rnd_valid immediately.

Optional Feature:
- Macro: TRNG_HEALTH_EN.
- With the macro:
  - A repetition-count test runs on synced bits at each strobe while enable=1.
  - Its counter resets to 1 on a bit change and increments on a repeat, saturating.
  - When the run length reaches RCT_CUTOFF, health_fail is set (sticky until rst).
  - Transfers to the holding register are blocked while health_fail=1; a word already valid stays valid until consumed.
- Without the macro: health_fail is tied to 0, RCT_CUTOFF is unused, and no counter logic is generated.

Decomposition:
- Package trng_pkg holds:
  - the debias state enum (EMPTY, HAVE_FIRST);
  - default constants for NUM_RO, WORD_WIDTH, SAMPLE_DIV and RCT_CUTOFF;
  - the fill-counter width function clog2(WORD_WIDTH+1).
- One sub-module, trng_sync: the 2-flop synchroniser, 1 bit wide, with async active-high reset to 0.

Test Plan:
- NUM_RO=4, SAMPLE_DIV=1, WORD_WIDTH=8; strobe-aligned raw pairs 01,10,01,10,01,10,01,10 -> rnd_data=8'h55, rnd_valid high 3 clocks after the last pair.
- Pairs 00 and 11 repeated 100 times -> rnd_valid stays 0, overrun=0.
- Hold rnd_ready=0 and feed 3 full words -> first word stays stable, second fills the shift register, then overrun=1. Raise rnd_ready -> 8'h55 is consumed, the second word is presented next cycle, and overrun stays 1.
- Drop enable after 5 corrected bits -> fill is cleared; re-enable and feed 8 pairs -> output is exactly those 8 bits.
- Assert rst with rnd_valid=1 -> rnd_valid, rnd_data, overrun and health_fail are 0 immediately, without waiting for a clock edge.
- TRNG_HEALTH_EN, RCT_CUTOFF=16, constant raw=1 -> health_fail=1 at the 16th strobe and no further words transfer. Without the macro -> health_fail stays 0.
